hx8352_controller_bus_reader: RTL and testbench
===============================================

# hx8352_controller_bus_reader

Read-side engine for the HX8352 8080-style parallel LCD bus, the counterpart of the write path. It releases the shared 16-bit data bus, strobes `lcd_rd` low with programmable timing, and samples the panel's data into a register. It reports each word with a one-cycle valid pulse, and supports bursts and the controller's mandatory dummy read. It sits beside the bus writer under the LCD top level. The top level muxes `lcd_rs`/`lcd_wr`/`lcd_rd` by `busy` and uses `lcd_data_oe` as the tristate enable.

## Interface
Parameters:
- `RD_LOW_CYCLES`, 2, clocks `lcd_rd` is held low per word (≥1)
- `RD_HIGH_CYCLES`, 1, clocks `lcd_rd` is held high after each word before the next strobe or bus release (≥1)

Ports:
- Clock/reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `read_step` in 1: start request; rising edge detected internally
- `data_command` in 1: RS level for the transaction (0 = index/status, 1 = data); sampled at start
- `burst_len` in 8: words to deliver; sampled at start; 0 is treated as 1
- `lcd_data_in` in 16: panel data bus (input side of the tristate)
- `busy` out 1: transaction in progress
- `data_output` out 16: last captured word
- `data_valid` out 1: one-cycle pulse per delivered word
- `lcd_rs` out 1: register-select strobe
- `lcd_wr` out 1: constant high (never asserted)
- `lcd_rd` out 1: active-low read strobe
- `lcd_data_oe` out 1: 1 = FPGA may drive the bus; 0 = the panel drives it

## Operation
- All outputs are registered.
- Reset values:
  - `busy`=0, `data_output`=0, `data_valid`=0
  - `lcd_rs`=1, `lcd_wr`=1, `lcd_rd`=1, `lcd_data_oe`=1
  - state IDLE, all counters 0
- Start condition: `read_step`=1 while its registered copy is 0.
- State IDLE:
  - On start, latch `data_command` and the effective burst length, then go to TURN.
  - While in IDLE, `lcd_rs`=1 and `lcd_data_oe`=1.
- TURN (1 clock):
  - `busy`=1, `lcd_data_oe`=0, `lcd_rs`=latched value, `lcd_rd`=1; bus turnaround.
  - Next state: STROBE.
- STROBE:
  - `lcd_rd`=0 for exactly `RD_LOW_CYCLES` clocks.
  - On the edge ending the last low clock: capture `lcd_data_in`, set `lcd_rd`=1, go to RECOVER.
  - For a delivered word, also update `data_output` and pulse `data_valid` at that same edge.
- RECOVER:
  - `lcd_rd`=1 for `RD_HIGH_CYCLES` clocks.
  - If words remain: go to STROBE.
  - Otherwise: go to IDLE, setting `busy`=0 and `lcd_data_oe`=1 on the same edge.
- `lcd_data_in` is ignored at every edge except the capture edge.
- Start edges seen while `busy`=1 are ignored; the edge register still tracks the input.
- `read_step` held high starts exactly one transaction.
- `rst` mid-transaction: on the next edge all outputs return to reset values and the state goes to IDLE. No `data_valid` is emitted for the interrupted word.
- The word counter is 9 bits, so there is no overflow at `burst_len`=255 even with a dummy read.

## Timing
- Edge 0 is the start edge.
- Single word, dummy disabled, defaults (`RD_LOW_CYCLES`=2, `RD_HIGH_CYCLES`=1):
  - `busy`/`lcd_data_oe`=0 after edge 0
  - `lcd_rd`=0 after edges 1–2
  - capture at edge 3: `data_valid`=1 for one cycle
  - `busy`=0 after edge 4
- General case:
  - first capture at edge `1+RD_LOW_CYCLES`
  - word period `RD_LOW_CYCLES+RD_HIGH_CYCLES`
  - `busy` clears `1+N·(RD_LOW_CYCLES+RD_HIGH_CYCLES)` edges after start, where N is the number of strobes.
- The earliest next start edge is the edge after `busy` falls.

## Configuration
- `HX8352_READ_DUMMY_EN` defined:
  - Each transaction issues one extra leading strobe with full timing.
  - That word is captured but discarded: no `data_valid`, `data_output` unchanged.
  - Strobes per transaction = burst + 1.
- Not defined:
  - Strobes = burst.
  - Every strobe produces `data_valid`.

## Structure
- Package `hx8352_pkg`:
  - state enum: IDLE, TURN, STROBE, RECOVER
  - `HIGH`/`LOW` constants
  - bus width 16
  - default timing constants (shared with the writer)
- Sub-module `hx8352_edge_detect`:
  - register plus rising-edge pulse on `read_step`
  - synchronous active-high reset
  - reusable by the writer

## Test plan
- Reset then idle, no `read_step` → all outputs hold reset values for 20 cycles.
- `burst_len`=1, `data_command`=0, `lcd_data_in`=16'hA55A, defaults, dummy off:
  - `lcd_rs`=0 and `lcd_rd` low for exactly 2 cycles
  - `data_valid` one cycle with `data_output`=16'hA55A, 3 edges after start
  - `busy` clears after edge 4
- `burst_len`=3, model returns 16'h0001/0002/0003 per strobe:
  - three `data_valid` pulses, 3 cycles apart, in that order
  - `lcd_rd` high ≥1 cycle between strobes
- `HX8352_READ_DUMMY_EN`, `burst_len`=1, model returns 16'hDEAD then 16'hBEEF:
  - two strobes, one `data_valid`
  - `data_output`=16'hBEEF
- `read_step` pulsed again mid-burst, and `burst_len`=0:
  - no extra transaction
  - `burst_len`=0 yields exactly one word
- `rst` asserted during STROBE:
  - next edge `lcd_rd`=1, `lcd_data_oe`=1, `busy`=0, no `data_valid`
  - a subsequent start works normally

Source files
------------

// File: rtl/hx8352_pkg.sv
// Shared types and constants for the HX8352 8080-style bus reader and writer.
package hx8352_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        STROBE,
        RECOVER
    } state_t;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam int BUS_W = 16;

    // Default strobe timing in clocks, shared by the read and write paths.
    localparam int DEF_RD_LOW_CYCLES  = 2;
    localparam int DEF_RD_HIGH_CYCLES = 1;
    localparam int DEF_WR_LOW_CYCLES  = 1;
    localparam int DEF_WR_HIGH_CYCLES = 1;

endpackage

// File: rtl/hx8352_edge_detect.sv
// Registers a level input and flags its rising edge (combinational pulse
// against the registered copy). Synchronous active-high reset.
module hx8352_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/hx8352_controller_bus_reader.sv
// Read engine for the HX8352 parallel bus: turnaround, timed lcd_rd strobes,
// word capture with one-cycle valid. Optional leading dummy read when
// HX8352_READ_DUMMY_EN is defined.
module hx8352_controller_bus_reader
    import hx8352_pkg::*;
#(
    parameter int RD_LOW_CYCLES  = DEF_RD_LOW_CYCLES,
    parameter int RD_HIGH_CYCLES = DEF_RD_HIGH_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_step,
    input  logic             data_command,
    input  logic [7:0]       burst_len,
    input  logic [BUS_W-1:0] lcd_data_in,
    output logic             busy,
    output logic [BUS_W-1:0] data_output,
    output logic             data_valid,
    output logic             lcd_rs,
    output logic             lcd_wr,
    output logic             lcd_rd,
    output logic             lcd_data_oe
);

`ifdef HX8352_READ_DUMMY_EN
    localparam logic DUMMY_EN = 1'b1;
`else
    localparam logic DUMMY_EN = 1'b0;
`endif

    state_t           state, state_n;
    logic [15:0]      tcnt, tcnt_n;
    logic [8:0]       words_left, words_n;
    logic             dummy_pend, dummy_n;
    logic             busy_n, valid_n, rs_n, rd_n, oe_n;
    logic [BUS_W-1:0] dout_n;
    logic [8:0]       eff_burst;
    logic             start;

    hx8352_edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (read_step),
        .rise (start)
    );

    // 9-bit count leaves room for burst 255 plus the dummy strobe.
    assign eff_burst = (burst_len == 8'd0) ? 9'd1 : {1'b0, burst_len};

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        words_n = words_left;
        dummy_n = dummy_pend;
        busy_n  = busy;
        valid_n = 1'b0;
        rs_n    = lcd_rs;
        rd_n    = lcd_rd;
        oe_n    = lcd_data_oe;
        dout_n  = data_output;
        case (state)
            IDLE: begin
                rs_n = HIGH;
                oe_n = HIGH;
                if (start) begin
                    state_n = TURN;
                    busy_n  = 1'b1;
                    oe_n    = LOW;
                    rs_n    = data_command;
                    words_n = eff_burst + {8'd0, DUMMY_EN};
                    dummy_n = DUMMY_EN;
                    tcnt_n  = 16'd0;
                end
            end
            TURN: begin
                state_n = STROBE;
                rd_n    = LOW;
                tcnt_n  = 16'd0;
            end
            STROBE: begin
                if (tcnt == 16'(RD_LOW_CYCLES - 1)) begin
                    state_n = RECOVER;
                    rd_n    = HIGH;
                    tcnt_n  = 16'd0;
                    words_n = words_left - 9'd1;
                    if (dummy_pend) begin
                        dummy_n = 1'b0;
                    end else begin
                        valid_n = 1'b1;
                        dout_n  = lcd_data_in;
                    end
                end else begin
                    tcnt_n = tcnt + 16'd1;
                end
            end
            RECOVER: begin
                if (tcnt == 16'(RD_HIGH_CYCLES - 1)) begin
                    tcnt_n = 16'd0;
                    if (words_left != 9'd0) begin
                        state_n = STROBE;
                        rd_n    = LOW;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        oe_n    = HIGH;
                        rs_n    = HIGH;
                    end
                end else begin
                    tcnt_n = tcnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tcnt        <= 16'd0;
            words_left  <= 9'd0;
            dummy_pend  <= 1'b0;
            busy        <= 1'b0;
            data_output <= '0;
            data_valid  <= 1'b0;
            lcd_rs      <= HIGH;
            lcd_wr      <= HIGH;
            lcd_rd      <= HIGH;
            lcd_data_oe <= HIGH;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            words_left  <= words_n;
            dummy_pend  <= dummy_n;
            busy        <= busy_n;
            data_output <= dout_n;
            data_valid  <= valid_n;
            lcd_rs      <= rs_n;
            lcd_wr      <= HIGH;
            lcd_rd      <= rd_n;
            lcd_data_oe <= oe_n;
        end
    end

endmodule

// File: tb/tb_hx8352_controller_bus_reader.sv
// Directed bench for hx8352_controller_bus_reader: per-edge strobe timing
// model, a panel model feeding words per strobe, and an expected-word queue.
module tb_hx8352_controller_bus_reader;

`ifdef HX8352_READ_DUMMY_EN
    localparam int DUMMY = 1;
`else
    localparam int DUMMY = 0;
`endif
    localparam int LOW_C  = 2;
    localparam int HIGH_C = 1;
    localparam int PER    = LOW_C + HIGH_C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_step = 1'b0;
    logic        data_command = 1'b0;
    logic [7:0]  burst_len = 8'd0;
    logic [15:0] lcd_data_in = 16'd0;
    logic        busy, data_valid, lcd_rs, lcd_wr, lcd_rd, lcd_data_oe;
    logic [15:0] data_output;

    logic [15:0] exp_q[$];
    logic [15:0] panel_q[$];
    logic [15:0] last_exp = 16'd0;
    logic        rd_prev = 1'b1;
    int          total = 0;
    int          passed = 0;
    int          fails = 0;
    int          valid_cnt = 0;

    hx8352_controller_bus_reader #(
        .RD_LOW_CYCLES  (LOW_C),
        .RD_HIGH_CYCLES (HIGH_C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .read_step    (read_step),
        .data_command (data_command),
        .burst_len    (burst_len),
        .lcd_data_in  (lcd_data_in),
        .busy         (busy),
        .data_output  (data_output),
        .data_valid   (data_valid),
        .lcd_rs       (lcd_rs),
        .lcd_wr       (lcd_wr),
        .lcd_rd       (lcd_rd),
        .lcd_data_oe  (lcd_data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {busy, lcd_data_oe, lcd_rs, lcd_rd, lcd_wr, data_valid}
    function automatic logic [5:0] outs();
        return {busy, lcd_data_oe, lcd_rs, lcd_rd, lcd_wr, data_valid};
    endfunction

    task automatic add_word(input logic [15:0] w, input bit keep);
        panel_q.push_back(w);
        if (keep) exp_q.push_back(w);
    endtask

    task automatic add_dummy();
        if (DUMMY != 0) add_word(16'($urandom), 1'b0);
    endtask

    // Runs one transaction and checks every output after every edge.
    task automatic run_txn(input logic dc, input logic [7:0] bl, input bit restep);
        int words, n, last, v0;
        logic e_busy, e_rd, e_valid;
        words = (bl == 8'd0) ? 1 : int'(bl);
        n     = words + DUMMY;
        last  = 1 + n * PER;
        v0    = valid_cnt;
        rd_prev = 1'b1;
        @(negedge clk);
        data_command = dc;
        burst_len    = bl;
        read_step    = 1'b1;
        for (int k = 0; k <= last + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (restep) begin
                if (k == 2) read_step = 1'b0;
                if (k == 4) read_step = 1'b1;
            end else if (k == 0) begin
                read_step = 1'b0;
            end
            // panel model: a new word appears when lcd_rd falls, noise otherwise
            if (lcd_rd == 1'b0 && rd_prev == 1'b1) begin
                if (panel_q.size() > 0) lcd_data_in = panel_q.pop_front();
            end else if (lcd_rd == 1'b1) begin
                lcd_data_in = 16'($urandom);
            end
            rd_prev = lcd_rd;
            e_busy  = (k < last);
            e_rd    = !(k >= 1 && k <= n * PER && ((k - 1) % PER) < LOW_C);
            e_valid = (k >= 1 && k <= n * PER && ((k - 1) % PER) == LOW_C
                       && ((k - 1) / PER) >= DUMMY);
            check($sformatf("edge%0d_outs", k), 32'(outs()),
                  32'({e_busy, !e_busy, (e_busy ? dc : 1'b1), e_rd, 1'b1, e_valid}));
            if (data_valid) begin
                valid_cnt++;
                if (exp_q.size() > 0) last_exp = exp_q.pop_front();
            end
            check($sformatf("edge%0d_dout", k), 32'(data_output), 32'(last_exp));
        end
        check("valid_count", 32'(valid_cnt - v0), 32'(words));
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        read_step = 1'b0;
        panel_q.delete();
    endtask

    initial begin
        // reset, then idle with no request
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outs", 32'(outs()), 32'(6'b011110));
            check("idle_dout", 32'(data_output), 32'd0);
        end

        // single word, index register
        add_dummy();
        add_word(16'hA55A, 1'b1);
        run_txn(1'b0, 8'd1, 1'b0);

        // three-word data burst
        add_dummy();
        add_word(16'h0001, 1'b1);
        add_word(16'h0002, 1'b1);
        add_word(16'h0003, 1'b1);
        run_txn(1'b1, 8'd3, 1'b0);

`ifdef HX8352_READ_DUMMY_EN
        add_word(16'hDEAD, 1'b0);
        add_word(16'hBEEF, 1'b1);
        run_txn(1'b1, 8'd1, 1'b0);
        check("dummy_dout", 32'(data_output), 32'h0000BEEF);
`endif

        // second rising edge while busy, read_step left high afterwards
        add_dummy();
        for (int i = 0; i < 4; i++) add_word(16'($urandom), 1'b1);
        run_txn(1'b1, 8'd4, 1'b1);

        // burst_len 0 delivers one word
        add_dummy();
        add_word(16'h5AA5, 1'b1);
        run_txn(1'b0, 8'd0, 1'b0);

        // reset in the middle of a strobe
        @(negedge clk);
        lcd_data_in  = 16'h1234;
        data_command = 1'b1;
        burst_len    = 8'd2;
        read_step    = 1'b1;
        @(negedge clk);
        read_step = 1'b0;
        @(negedge clk);
        check("pre_rst_rd", 32'(lcd_rd), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outs", 32'(outs()), 32'(6'b011110));
        check("rst_dout", 32'(data_output), 32'd0);
        last_exp = 16'd0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_outs", 32'(outs()), 32'(6'b011110));

        add_dummy();
        add_word(16'hC3C3, 1'b1);
        add_word(16'h3C3C, 1'b1);
        run_txn(1'b1, 8'd2, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
